// File: rtl/note_pkg.sv
// Shared types and constants for the note playback reader and its tone generator.
package note_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PLAY, GAP} state_e;

  localparam int NOTE_W    = 4;
  localparam int OCT_W     = 2;
  localparam int MEM_DEPTH = 16;
  localparam logic [NOTE_W-1:0] REST_NOTE = 4'd0;

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles audio every half_period_i enabled cycles.
module tone_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic [31:0] half_period_i,
  output logic        audio_out_o
);

  logic [31:0] cnt_q, cnt_d;
  logic        audio_q, audio_d;

  // Disabled or a zero half period is a rest: output and counter stay cleared.
  always_comb begin
    cnt_d   = '0;
    audio_d = 1'b0;
    if (en_i && (half_period_i != 32'd0)) begin
      if (cnt_q == half_period_i - 32'd1) begin
        cnt_d   = '0;
        audio_d = ~audio_q;
      end else begin
        cnt_d   = cnt_q + 32'd1;
        audio_d = audio_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      audio_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      audio_q <= audio_d;
    end
  end

  assign audio_out_o = audio_q;

endmodule

// File: rtl/note_player.sv
// Playback reader: steps the note memory, holds each note then a silent gap,
// and drives the audio pin through tone_gen.
module note_player
  import note_pkg::*;
#(
  parameter int ADDR_W      = $clog2(MEM_DEPTH),
  parameter int NOTE_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 500000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic                    loop_i,
  input  logic [ADDR_W-1:0]       last_addr_i,
  output logic [ADDR_W-1:0]       mem_addr_o,
  input  logic [OCT_W+NOTE_W-1:0] mem_q_i,
  output logic [NOTE_W-1:0]       note_o,
  output logic [OCT_W-1:0]        octave_o,
  input  logic [31:0]             half_period_i,
  output logic                    note_valid_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    audio_out_o
);

  localparam int DUR_MAX = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int DUR_W   = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;
  localparam logic [DUR_W-1:0] NOTE_LAST = DUR_W'(NOTE_CYCLES - 1);
  localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'(GAP_CYCLES - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [OCT_W-1:0]    octave_q, octave_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic                done_q, done_d;
  logic                advance;
  logic                tone_en;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    note_d   = note_q;
    octave_d = octave_q;
    dur_d    = dur_q;
    done_d   = 1'b0;
    advance  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = FETCH;
          addr_d  = '0;
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        {octave_d, note_d} = mem_q_i;
        dur_d   = '0;
        state_d = PLAY;
      end
      PLAY: begin
        if (dur_q == NOTE_LAST) begin
          dur_d = '0;
          if (GAP_CYCLES == 0) advance = 1'b1;
          else                 state_d = GAP;
        end else begin
          dur_d = dur_q + DUR_W'(1);
        end
      end
      GAP: begin
        if (dur_q == GAP_LAST) begin
          dur_d   = '0;
          advance = 1'b1;
        end else begin
          dur_d = dur_q + DUR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // >= rather than == so a last_addr lowered mid-play can never be overrun.
    if (advance) begin
      if (addr_q < last_addr_i) begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = FETCH;
      end else if (loop_i) begin
        addr_d  = '0;
        state_d = FETCH;
      end else begin
        addr_d  = '0;
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end

    if (stop_i) begin
      state_d = IDLE;
      addr_d  = '0;
      dur_d   = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      note_q   <= '0;
      octave_q <= '0;
      dur_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      note_q   <= note_d;
      octave_q <= octave_d;
      dur_q    <= dur_d;
      done_q   <= done_d;
    end
  end

  // Gating on the next state as well clears audio on the very edge PLAY is left.
  assign tone_en = (state_q == PLAY) && (state_d == PLAY) && (note_q != REST_NOTE);

  tone_gen u_tone_gen (
    .clk           (clk),
    .reset         (reset),
    .en_i          (tone_en),
    .half_period_i (half_period_i),
    .audio_out_o   (audio_out_o)
  );

  assign mem_addr_o   = addr_q;
  assign note_o       = note_q;
  assign octave_o     = octave_q;
  assign note_valid_o = (state_q == PLAY);
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player with NOTE_CYCLES=8, GAP_CYCLES=2 and a 1-cycle RAM model.
module tb_note_player;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i, stop_i, loop_i;
  logic [3:0]  last_addr;
  logic [3:0]  mem_addr;
  logic [5:0]  mem_q;
  logic [3:0]  note;
  logic [1:0]  octave;
  logic [31:0] half_period;
  logic        note_valid, busy, done, audio_out;
  logic [5:0]  ram [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_q <= ram[mem_addr];

  note_player #(.ADDR_W(4), .NOTE_CYCLES(8), .GAP_CYCLES(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .stop_i        (stop_i),
    .loop_i        (loop_i),
    .last_addr_i   (last_addr),
    .mem_addr_o    (mem_addr),
    .mem_q_i       (mem_q),
    .note_o        (note),
    .octave_o      (octave),
    .half_period_i (half_period),
    .note_valid_o  (note_valid),
    .busy_o        (busy),
    .done_o        (done),
    .audio_out_o   (audio_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start_i = 1'b0; stop_i = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Afterwards the bench sits in cycle 0, one edge after start was sampled.
  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_i = 1'b0; stop_i = 1'b0; loop_i = 1'b0;
    last_addr = 4'd0; half_period = 32'd0;
    for (int i = 0; i < 16; i++) ram[i] = 6'h00;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({mem_addr, note, octave, note_valid, busy, done, audio_out} !== 14'd0) begin
      errors++;
      $display("[TB] FAIL reset_values got addr=%0h note=%0h oct=%0h nv=%b busy=%b done=%b audio=%b want all 0",
               mem_addr, note, octave, note_valid, busy, done, audio_out);
    end
  endtask

  task automatic test_sequence();
    int done_cnt = 0;
    logic exp_nv, exp_busy, exp_done;
    logic [3:0] exp_addr;
    do_reset();
    ram[0] = 6'h11; ram[1] = 6'h22;
    last_addr = 4'd1; loop_i = 1'b0; half_period = 32'd0;
    pulse_start();
    for (int c = 0; c <= 25; c++) begin
      exp_nv   = ((c >= 2) && (c <= 9)) || ((c >= 14) && (c <= 21));
      exp_addr = ((c >= 12) && (c <= 23)) ? 4'd1 : 4'd0;
      exp_busy = (c < 24);
      exp_done = (c == 24);
      checks += 4;
      if (note_valid !== exp_nv) begin
        errors++; $display("[TB] FAIL seq_note_valid c=%0d got %b want %b", c, note_valid, exp_nv);
      end
      if (mem_addr !== exp_addr) begin
        errors++; $display("[TB] FAIL seq_mem_addr c=%0d got %0h want %0h", c, mem_addr, exp_addr);
      end
      if (busy !== exp_busy) begin
        errors++; $display("[TB] FAIL seq_busy c=%0d got %b want %b", c, busy, exp_busy);
      end
      if (done !== exp_done) begin
        errors++; $display("[TB] FAIL seq_done c=%0d got %b want %b", c, done, exp_done);
      end
      if (c == 2 || c == 14) begin
        checks++;
        if ({octave, note} !== ((c == 2) ? 6'h11 : 6'h22)) begin
          errors++; $display("[TB] FAIL seq_capture c=%0d got %h", c, {octave, note});
        end
      end
      if (done === 1'b1) done_cnt++;
      tick();
    end
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("[TB] FAIL seq_done_count got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_tone();
    int exp_audio [13] = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
    do_reset();
    ram[0] = 6'h11; last_addr = 4'd0; loop_i = 1'b0; half_period = 32'd3;
    pulse_start();
    for (int c = 0; c <= 12; c++) begin
      checks++;
      if (audio_out !== exp_audio[c][0]) begin
        errors++; $display("[TB] FAIL tone_audio c=%0d got %b want %0d", c, audio_out, exp_audio[c]);
      end
      tick();
    end
  endtask

  task automatic test_rest();
    do_reset();
    ram[0] = 6'h10; last_addr = 4'd0; loop_i = 1'b0; half_period = 32'd3;
    pulse_start();
    for (int c = 0; c <= 12; c++) begin
      checks += 2;
      if (audio_out !== 1'b0) begin
        errors++; $display("[TB] FAIL rest_audio c=%0d got %b want 0", c, audio_out);
      end
      if (done !== (c == 12)) begin
        errors++; $display("[TB] FAIL rest_done c=%0d got %b want %b", c, done, (c == 12));
      end
      tick();
    end
  endtask

  task automatic test_loop();
    do_reset();
    for (int i = 0; i < 16; i++) ram[i] = {2'd2, 4'(15 - i)};
    last_addr = 4'hF; loop_i = 1'b1; half_period = 32'd0;
    pulse_start();
    for (int c = 0; c <= 200; c++) begin
      checks += 2;
      if (done !== 1'b0) begin
        errors++; $display("[TB] FAIL loop_done c=%0d got %b want 0", c, done);
      end
      if (busy !== 1'b1) begin
        errors++; $display("[TB] FAIL loop_busy c=%0d got %b want 1", c, busy);
      end
      if (c == 180 || c == 192) begin
        checks++;
        if (mem_addr !== ((c == 180) ? 4'hF : 4'h0)) begin
          errors++; $display("[TB] FAIL loop_addr c=%0d got %0h", c, mem_addr);
        end
      end
      if (c == 194) begin
        checks++;
        if ({octave, note} !== 6'h2F) begin
          errors++; $display("[TB] FAIL loop_restart_note got %h want 2f", {octave, note});
        end
      end
      tick();
    end
    stop_i = 1'b1; tick(); stop_i = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("[TB] FAIL loop_stop_busy got %b want 0", busy);
    end
  endtask

  task automatic test_stop();
    do_reset();
    ram[0] = 6'h11; ram[1] = 6'h22;
    last_addr = 4'd1; loop_i = 1'b0; half_period = 32'd3;
    pulse_start();
    repeat (17) tick();
    checks++;
    if ({mem_addr, audio_out, note_valid} !== 6'b0001_1_1) begin
      errors++; $display("[TB] FAIL stop_pre got addr=%0h audio=%b nv=%b want 1 1 1", mem_addr, audio_out, note_valid);
    end
    stop_i = 1'b1; tick(); stop_i = 1'b0;
    checks++;
    if ({mem_addr, audio_out, note_valid, busy, done} !== 8'd0) begin
      errors++; $display("[TB] FAIL stop_idle got addr=%0h audio=%b nv=%b busy=%b done=%b want 0",
                         mem_addr, audio_out, note_valid, busy, done);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++; $display("[TB] FAIL stop_after c=%0d got busy=%b done=%b want 0 0", c, busy, done);
      end
    end
    start_i = 1'b1; stop_i = 1'b1; tick(); start_i = 1'b0; stop_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("[TB] FAIL start_stop_idle c=%0d got busy=%b want 0", c, busy);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_gap();
    do_reset();
    ram[0] = 6'h11; ram[1] = 6'h22;
    last_addr = 4'd1; loop_i = 1'b0; half_period = 32'd3;
    pulse_start();
    repeat (22) tick();
    checks++;
    if ({mem_addr, note, busy, note_valid} !== 10'b0001_0010_1_0) begin
      errors++; $display("[TB] FAIL gap_pre got addr=%0h note=%0h busy=%b nv=%b", mem_addr, note, busy, note_valid);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if ({mem_addr, note, octave, note_valid, busy, done, audio_out} !== 14'd0) begin
      errors++; $display("[TB] FAIL gap_reset got addr=%0h note=%0h oct=%0h nv=%b busy=%b done=%b audio=%b want all 0",
                         mem_addr, note, octave, note_valid, busy, done, audio_out);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ram[0] = 6'h11; ram[1] = 6'h22;
    last_addr = 4'd1; loop_i = 1'b0; half_period = 32'd0;
    pulse_start();
    for (int c = 0; c <= 24; c++) begin
      checks += 2;
      if (mem_addr !== (((c >= 12) && (c <= 23)) ? 4'd1 : 4'd0)) begin
        errors++; $display("[TB] FAIL busy_start_addr c=%0d got %0h", c, mem_addr);
      end
      if (done !== (c == 24)) begin
        errors++; $display("[TB] FAIL busy_start_done c=%0d got %b want %b", c, done, (c == 24));
      end
      start_i = (c == 5 || c == 13);
      tick();
    end
    start_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_tone();
    test_rest();
    test_loop();
    test_stop();
    test_reset_mid_gap();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
